// File: rtl/alu_result_stage_pkg.sv
// Shared ALU encodings for the result stage: op codes, flag bit positions and
// the op classification used by the sticky status logic.
package alu_result_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101
  } alu_op_e;

  localparam int FLAGS_W = 4;
  localparam int OP_W    = 3;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_O = 0;

  // Only add/sub produce carry and overflow that are meaningful for status.
  function automatic logic is_arith(input logic [OP_W-1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_result_stage_skid_fifo.sv
// Two-entry skid FIFO. Ready/valid are pure functions of the registered
// occupancy, so no combinational path runs from either handshake side.
module alu_skid_fifo #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [PW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [PW-1:0] pop_data
);

  logic [PW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  assign push_ready = (count != 2'd2);
  assign pop_valid  = (count != 2'd0);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  // Head entry is masked to zero when empty so stale data never leaks out.
  assign pop_data = pop_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers results in a 2-entry skid FIFO and accumulates
// sticky carry/overflow status plus a saturating overflow counter.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_result,
  input  logic [FLAGS_W-1:0] in_flags,
  input  logic [OP_W-1:0]    in_op,
  input  logic [RD_W-1:0]    in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [FLAGS_W-1:0] out_flags,
  output logic [OP_W-1:0]    out_op,
  output logic [RD_W-1:0]    out_rd,
  output logic               out_we,
  input  logic               clr_sticky,
  output logic               sticky_c,
  output logic               sticky_o,
  output logic [7:0]         ovf_count
);

  localparam int PW = WIDTH + FLAGS_W + OP_W + RD_W;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_payload;
  logic          accept;
  logic          qual;
  logic          new_c;
  logic          new_o;

  assign in_payload = {in_result, in_flags, in_op, in_rd};

  alu_skid_fifo #(
    .PW (PW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (in_payload),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (out_payload)
  );

  assign {out_result, out_flags, out_op, out_rd} = out_payload;
  assign out_we = out_valid && (out_rd != '0);

  assign accept = in_valid && in_ready;
  assign qual   = accept && is_arith(in_op);
  assign new_c  = qual && in_flags[FLAG_C];
  assign new_o  = qual && in_flags[FLAG_O];

  // A clear coincident with a qualifying accept keeps only the new event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_c  <= 1'b0;
      sticky_o  <= 1'b0;
      ovf_count <= 8'd0;
    end else if (clr_sticky) begin
      sticky_c  <= new_c;
      sticky_o  <= new_o;
      ovf_count <= {7'd0, new_o};
    end else begin
      sticky_c <= sticky_c | new_c;
      sticky_o <= sticky_o | new_o;
      if (new_o && (ovf_count != 8'hFF)) begin
        ovf_count <= ovf_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: accepted results are queued, a
// negedge monitor checks presentation order, handshake levels and idle zeros.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_flags;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [2:0]  out_op;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        clr_sticky;
  logic        sticky_c;
  logic        sticky_o;
  logic [7:0]  ovf_count;

  int checks = 0;
  int errors = 0;

  logic [43:0] exp_q[$];
  logic        m_c;
  logic        m_o;
  int          m_cnt;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32), .RD_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_flags   (in_flags),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_op     (out_op),
    .out_rd     (out_rd),
    .out_we     (out_we),
    .clr_sticky (clr_sticky),
    .sticky_c   (sticky_c),
    .sticky_o   (sticky_o),
    .ovf_count  (ovf_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the queue holds exactly the accepted-but-not-popped results.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
      if (out_valid && exp_q.size() != 0) begin
        logic [43:0] e;
        e = exp_q[0];
        chk("out_result", {32'd0, out_result}, {32'd0, e[43:12]});
        chk("out_flags", {60'd0, out_flags}, {60'd0, e[11:8]});
        chk("out_op", {61'd0, out_op}, {61'd0, e[7:5]});
        chk("out_rd", {59'd0, out_rd}, {59'd0, e[4:0]});
        chk("out_we", {63'd0, out_we}, {63'd0, e[4:0] != 5'd0});
        if (out_ready) void'(exp_q.pop_front());
      end else if (!out_valid) begin
        chk("idle_data", {19'd0, out_result, out_flags, out_op, out_rd, out_we}, 64'd0);
      end
    end
  end

  // One cycle of stimulus, starting just after a rising edge; checks status after the edge.
  task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] fl,
                       input logic [2:0] op, input logic [4:0] rd, input logic ordy,
                       input logic clr, output logic acc);
    logic arith;
    in_valid   = v;
    in_result  = res;
    in_flags   = fl;
    in_op      = op;
    in_rd      = rd;
    out_ready  = ordy;
    clr_sticky = clr;
    acc   = v && in_ready;
    arith = acc && (op == 3'd0 || op == 3'd1);
    if (clr) begin
      m_c   = arith && fl[1];
      m_o   = arith && fl[0];
      m_cnt = (arith && fl[0]) ? 1 : 0;
    end else begin
      if (arith && fl[1]) m_c = 1'b1;
      if (arith && fl[0]) begin
        m_o = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back({res, fl, op, rd});
    chk("sticky_c", {63'd0, sticky_c}, {63'd0, m_c});
    chk("sticky_o", {63'd0, sticky_o}, {63'd0, m_o});
    chk("ovf_count", {56'd0, ovf_count}, 64'(m_cnt));
    in_valid   = 1'b0;
    clr_sticky = 1'b0;
  endtask

  // Holds a result on the input until accepted, within a cycle budget.
  task automatic send(input logic [31:0] res, input logic [3:0] fl, input logic [2:0] op,
                      input logic [4:0] rd, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) drive(1'b1, res, fl, op, rd, ordy, 1'b0, acc);
    chk("send_accepted", {63'd0, acc}, 64'd1);
  endtask

  task automatic idle(input logic ordy, input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 4'd0, 3'd0, 5'd0, ordy, 1'b0, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0; in_op = '0;
    in_rd = '0; out_ready = 1'b0; clr_sticky = 1'b0;
    m_c = 1'b0; m_o = 1'b0; m_cnt = 0;
    #2;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_we", {63'd0, out_we}, 64'd0);
    chk("rst_status", {53'd0, sticky_c, sticky_o, ovf_count, out_result != 0}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single ADD to rd 5 with C set
    send(32'h0000_0000, 4'b1010, 3'b000, 5'd5, 1'b1);
    idle(1'b1, 2);

    // Three back-to-back with downstream stalled; third must be held
    send(32'd1, 4'b0000, 3'b010, 5'd1, 1'b0);
    send(32'd2, 4'b0000, 3'b010, 5'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd3, 4'b0000, 3'b010, 5'd3, 1'b0, 1'b0, acc);
      chk("third_held", {63'd0, acc}, 64'd0);
    end
    send(32'd3, 4'b0000, 3'b010, 5'd3, 1'b1);
    idle(1'b1, 3);

    // Saturating overflow count
    for (int i = 0; i < 260; i++) send(32'(i), 4'b0001, 3'b001, 5'd7, 1'b1);
    chk("ovf_saturated", {56'd0, ovf_count}, 64'hFF);
    send(32'hAAAA, 4'b0011, 3'b010, 5'd8, 1'b1);
    chk("and_no_change", {54'd0, sticky_o, sticky_c, ovf_count}, {54'd0, 2'b11, 8'hFF});

    // Clear coincident with qualifying ADD O=1
    drive(1'b1, 32'h55, 4'b0001, 3'b000, 5'd9, 1'b1, 1'b1, acc);
    chk("clr_concurrent", {54'd0, sticky_o, sticky_c, ovf_count}, {54'd0, 2'b10, 8'd1});
    drive(1'b0, 32'd0, 4'd0, 3'd0, 5'd0, 1'b1, 1'b1, acc);

    // rd = 0 never writes
    send(32'h1234, 4'b0000, 3'b011, 5'd0, 1'b1);
    idle(1'b1, 2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      drive(($urandom_range(0, 3) != 0), $urandom, 4'($urandom), 3'($urandom),
            rd, ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0), acc);
    end
    idle(1'b1, 3);

    // Asynchronous reset with two buffered entries
    send(32'hC0FFEE, 4'b0011, 3'b000, 5'd4, 1'b0);
    send(32'hBEEF, 4'b0011, 3'b001, 5'd6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_out_we", {63'd0, out_we}, 64'd0);
    chk("arst_status", {54'd0, sticky_c, sticky_o, ovf_count}, 64'd0);
    chk("arst_data", {20'd0, out_result, out_flags, out_op, out_rd}, 64'd0);
    exp_q.delete();
    m_c = 1'b0; m_o = 1'b0; m_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 32'h77, 4'b0000, 3'b100, 5'd2, 1'b1, 1'b0, acc);
    chk("first_accept_after_reset", {63'd0, acc}, 64'd1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1'b1, 1);
    idle(1'b1, 1);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the result datapath width.
REQ-002 Parameter RD_W, default 5, SHALL set the destination-register index width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 in_valid  input  1  SHALL mark the upstream ALU result as valid this cycle.
REQ-006 in_ready  output  1  SHALL mark that the stage accepts a result this cycle.
REQ-007 in_result  input  WIDTH  SHALL carry the ALU result.
REQ-008 in_flags  input  4  SHALL carry {Z,N,C,O} from the ALU.
REQ-009 in_op  input  3  SHALL carry the ALU control code that produced the result.
REQ-010 in_rd  input  RD_W  SHALL carry the destination register index.
REQ-011 out_valid  output  1  SHALL mark that a buffered result is presented downstream.
REQ-012 out_ready  input  1  SHALL mark that downstream consumes the presented result.
REQ-013 out_result, out_flags, out_op, out_rd  outputs  WIDTH/4/3/RD_W  SHALL present the head entry.
REQ-014 out_we  output  1  SHALL be out_valid AND (out_rd != 0).
REQ-015 clr_sticky  input  1  SHALL be a single-cycle request to clear the sticky status.
REQ-016 sticky_c, sticky_o  outputs  1 each  SHALL be the accumulated carry/overflow status.
REQ-017 ovf_count  output  8  SHALL count accepted overflow results, saturating.

Function
REQ-018 Stage SHALL be a 2-entry FIFO (skid buffer) holding {result, flags, op, rd}.
REQ-019 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL be driven from registered state only: high when occupancy < 2.
REQ-021 out_valid SHALL be high when occupancy != 0; outputs SHALL come straight from the head-entry registers.
REQ-022 Latency SHALL be one cycle: a result accepted at edge k is presented from edge k onward (out_valid high in cycle k+1).
REQ-023 Sustained throughput SHALL be one result per cycle when out_ready is held high.
REQ-024 Push and pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-025 Occupancy 2: in_ready low; in_valid SHALL be ignored; no entry overwritten.
REQ-026 Occupancy 0: out_valid low; out_ready SHALL be ignored; out_result/out_flags/out_op/out_rd SHALL be 0.
REQ-027 Entries SHALL be presented while out_valid is high and out_ready is low, held stable until popped.
REQ-028 On accept with in_op = 3'b000 (ADD) or 3'b001 (SUB): sticky_c |= in_flags C; sticky_o |= in_flags O.
REQ-029 Other in_op values SHALL NOT change sticky bits or ovf_count.
REQ-030 On accept with ADD/SUB and O=1, ovf_count SHALL increment by 1, saturating at 8'hFF.
REQ-031 clr_sticky SHALL clear sticky_c, sticky_o and ovf_count on the next edge.
REQ-032 clr_sticky coincident with a qualifying accept: result after the edge SHALL reflect only the new event (sticky = new flag, ovf_count = new O).
REQ-033 FIFO pointers SHALL be 1-bit and wrap from 1 to 0.

Reset
REQ-034 rst_n low SHALL immediately clear occupancy, pointers, sticky_c, sticky_o and ovf_count.
REQ-035 During and after reset: in_ready = 1, out_valid = 0, out_we = 0, all out_* data = 0.
REQ-036 Reset mid-transfer SHALL discard all buffered entries; nothing SHALL be replayed.
REQ-037 Reset deassertion SHALL need no synchronisation inside this block; first accept permitted on the first edge after release.

Structure
REQ-038 Shared package SHALL hold ALU op codes (ADD=000, SUB=001, AND=010, OR=011, SLL=100, SRL=101) and flag bit indices (Z=3, N=2, C=1, O=0).
REQ-039 FIFO storage SHALL be one sub-module, alu_skid_fifo, parameterised on payload width; sticky/counter logic stays in the top.

Verification
REQ-040 Single ADD, rd=5, result 0x00000000, flags 4'b1010, out_ready=1 -> out_valid one cycle, out_we=1, sticky_c=1, sticky_o=0.
REQ-041 Three back-to-back accepts, out_ready=0 -> in_ready low after 2nd accept, 3rd held; release out_ready -> outputs in order 1,2,3, no loss.
REQ-042 SUB with O=1 repeated 260 times -> ovf_count = 8'hFF, sticky_o=1; AND with flags 4'b0011 -> no change.
REQ-043 clr_sticky concurrent with ADD O=1 -> sticky_o=1, ovf_count=1 after edge.
REQ-044 Result with rd=0 -> out_valid=1, out_we=0.
REQ-045 rst_n low asynchronously while 2 entries buffered -> out_valid=0, in_ready=1, counters 0 before next clk edge.
